// File: rtl/prg_mem_loader_if.sv
// Signal bundle for the program-RAM front end: byte-stream loader, word bus and RAM port.
// The slave modport is the loader's view; master is the view of whatever drives it.
interface prg_mem_loader_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int NB_COL     = 4,
   parameter int COL_WIDTH  = 8
);
   localparam int DW = NB_COL * COL_WIDTH;

   logic                  ld_start;
   logic [ADDR_WIDTH-1:0] ld_base_addr;
   logic                  ld_byte_valid;
   logic [COL_WIDTH-1:0]  ld_byte_data;
   logic                  ld_last;
   logic                  ld_byte_ready;
   logic                  ld_busy;
   logic                  ld_done;
   logic [ADDR_WIDTH:0]   ld_word_cnt;

   logic                  wb_stb_i;
   logic                  wb_we_i;
   logic [ADDR_WIDTH-1:0] wb_adr_i;
   logic [NB_COL-1:0]     wb_sel_i;
   logic [DW-1:0]         wb_dat_i;
   logic [DW-1:0]         wb_dat_o;
   logic                  wb_ack_o;

   logic [NB_COL-1:0]     mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic [DW-1:0]         mem_rdata;

   modport slave (
      input  ld_start, ld_base_addr, ld_byte_valid, ld_byte_data, ld_last,
      output ld_byte_ready, ld_busy, ld_done, ld_word_cnt,
      input  wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output ld_start, ld_base_addr, ld_byte_valid, ld_byte_data, ld_last,
      input  ld_byte_ready, ld_busy, ld_done, ld_word_cnt,
      output wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/prg_mem_loader.sv
// Program-RAM front end: packs a byte stream into little-endian words at auto-incrementing
// addresses, and shares the single RAM port with a word bus that is served only when idle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no load; bus requests served, ld_done pulses on first cycle
// ST_LOAD  | accepting stream bytes, writing each completed word
// ST_FLUSH | last byte taken; final (possibly partial) word being written
module prg_mem_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int NB_COL     = 4,
   parameter int COL_WIDTH  = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   prg_mem_loader_if.slave  bus
);
   localparam int DW = NB_COL * COL_WIDTH;
   localparam int CW = (NB_COL > 1) ? $clog2(NB_COL) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(NB_COL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [DW-1:0]         buf_q, buf_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  wr_pend_q, wr_pend_d;
   logic [NB_COL-1:0]     wr_mask_q, wr_mask_d;
   logic [DW-1:0]         wr_data_q, wr_data_d;
   logic                  ack_q, ack_d;
   logic                  done_q, done_d;

   logic                  byte_ready;
   logic                  bus_acc;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DW-1:0]         word_in;
   logic [NB_COL-1:0]     fill_mask;
   logic [NB_COL-1:0]     mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DW-1:0]         mem_wdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         buf_q     <= '0;
         base_q    <= '0;
         cnt_q     <= '0;
         wr_pend_q <= 1'b0;
         wr_mask_q <= '0;
         wr_data_q <= '0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         buf_q     <= buf_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         wr_pend_q <= wr_pend_d;
         wr_mask_q <= wr_mask_d;
         wr_data_q <= wr_data_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
      end
   end

   // Columns 0..col_q are filled once the incoming byte lands in col_q.
   always_comb begin
      fill_mask = '0;
      for (int i = 0; i < NB_COL; i++) begin
         fill_mask[i] = (CW'(i) <= col_q);
      end
   end

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      buf_d      = buf_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      wr_pend_d  = 1'b0;
      wr_mask_d  = wr_mask_q;
      wr_data_d  = wr_data_q;
      ack_d      = 1'b0;
      done_d     = 1'b0;
      byte_ready = 1'b0;
      bus_acc    = 1'b0;

      ld_addr = base_q + cnt_q[ADDR_WIDTH-1:0];
      word_in = buf_q;
      word_in[int'(col_q)*COL_WIDTH +: COL_WIDTH] = bus.ld_byte_data;

      // The word count advances as each buffered word reaches the RAM.
      if (wr_pend_q) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.ld_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               col_d   = '0;
               buf_d   = '0;
               base_d  = bus.ld_base_addr;
            end else if (bus.wb_stb_i && !ack_q) begin
               bus_acc = 1'b1;
               ack_d   = 1'b1;
            end
         end
         ST_LOAD: begin
            byte_ready = 1'b1;
            if (bus.ld_byte_valid) begin
               if ((col_q == COL_LAST) || bus.ld_last) begin
                  wr_pend_d = 1'b1;
                  wr_data_d = word_in;
                  wr_mask_d = fill_mask;
                  col_d     = '0;
                  buf_d     = '0;
               end else begin
                  buf_d = word_in;
                  col_d = col_q + 1'b1;
               end
               if (bus.ld_last) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pending loader writes only exist outside IDLE, so they never collide with a bus access.
   always_comb begin
      mem_we    = '0;
      mem_addr  = (state_q == ST_IDLE) ? bus.wb_adr_i : ld_addr;
      mem_wdata = bus.wb_dat_i;
      if (wr_pend_q) begin
         mem_we    = wr_mask_q;
         mem_wdata = wr_data_q;
      end else if (bus_acc && bus.wb_we_i) begin
         mem_we = bus.wb_sel_i;
      end
   end

   assign bus.mem_we        = mem_we;
   assign bus.mem_addr      = mem_addr;
   assign bus.mem_wdata     = mem_wdata;
   assign bus.ld_byte_ready = byte_ready;
   assign bus.ld_busy       = (state_q != ST_IDLE);
   assign bus.ld_done       = done_q;
   assign bus.ld_word_cnt   = cnt_q;
   assign bus.wb_ack_o      = ack_q;
   assign bus.wb_dat_o      = ack_q ? bus.mem_rdata : '0;
endmodule

// File: doc/prg_mem_loader.md
Name: prg_mem_loader

Overview:
- Front-end stage sitting directly upstream of the byte-write-enable program RAM (single port, 1-cycle registered read, read output held while any write enable is set).
- Two masters share the one RAM port: a byte-stream loader (UART/SPI bring-up path) and a simple Wishbone-style word bus (core/debug access).
- The loader packs bytes little-endian into words, writes them at auto-incrementing addresses, and has priority over the bus while a load is active.

Parameters:
ADDR_WIDTH  12  RAM word-address width
NB_COL  4  byte columns per word
COL_WIDTH  8  bits per column; stream byte width

Ports:
clock  in  1  single clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
ld_start  in  1  pulse: begin load at ld_base_addr
ld_base_addr  in  ADDR_WIDTH  first word address of load
ld_byte_valid  in  1  stream byte valid
ld_byte_data  in  COL_WIDTH  stream byte
ld_last  in  1  qualifies final byte, sampled with valid
ld_byte_ready  out  1  loader accepts byte
ld_busy  out  1  load in progress
ld_done  out  1  one-cycle pulse at load completion
ld_word_cnt  out  ADDR_WIDTH+1  words written by current/last load
wb_stb_i  in  1  bus request
wb_we_i  in  1  1 = write
wb_adr_i  in  ADDR_WIDTH  word address
wb_sel_i  in  NB_COL  byte selects
wb_dat_i  in  NB_COL*COL_WIDTH  write data
wb_dat_o  out  NB_COL*COL_WIDTH  read data, valid with ack
wb_ack_o  out  1  one-cycle acknowledge
mem_we  out  NB_COL  RAM byte write enables
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  NB_COL*COL_WIDTH  RAM write data
mem_rdata  in  NB_COL*COL_WIDTH  RAM read data (registered in RAM)

Behaviour:
- Reset: all registered outputs 0. FSM=IDLE, ld_byte_ready=0, ld_word_cnt=0, column index 0, word buffer 0, write-pending flag 0. Reset mid-load discards the partial word; no further RAM writes occur.
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE -> LOAD on ld_start. Clears ld_word_cnt and column index; latches ld_base_addr.
  - LOAD -> FLUSH when a byte with ld_last is accepted.
  - FLUSH -> IDLE after the final write cycle. ld_done pulses in the first IDLE cycle.
  - ld_start is ignored in LOAD/FLUSH. ld_busy=1 in LOAD and FLUSH.
- Stream:
  - ld_byte_ready=1 only in LOAD; a byte transfers when valid&ready.
  - Byte k of a word goes to column k (column 0 = bits COL_WIDTH-1:0).
  - Word completes on the byte filling column NB_COL-1, or on ld_last. Completion copies buffer+incoming byte and the column mask into write registers and sets write-pending.
  - Next cycle: mem_we=mask, mem_addr=(base+ld_word_cnt) mod 2**ADDR_WIDTH, mem_wdata=word. ld_word_cnt increments (wraps modulo 2**(ADDR_WIDTH+1)).
  - Partial last word writes only the filled columns.
  - Loader sustains 1 byte/cycle with no bubbles; a new byte may be accepted in the same cycle as the previous word's write.
- Bus (served only in IDLE, and only when ld_start is not high that cycle):
  - Request accepted in cycle N when wb_stb_i=1 and wb_ack_o=0. mem_addr=wb_adr_i; mem_we = wb_we_i ? wb_sel_i : 0; mem_wdata=wb_dat_i.
  - wb_ack_o=1 in cycle N+1 only. For reads, wb_dat_o=mem_rdata during N+1.
  - The master drops stb after ack, giving a maximum of 1 transfer per 2 cycles.
  - During LOAD/FLUSH, bus requests stall with no ack; they are served after return to IDLE.
- Simultaneous ld_start and wb_stb_i in IDLE: the load wins, and the bus request stalls.
- A bus request accepted the cycle before ld_start still acks normally. The loader's first write occurs at N+2 or later, so the read data is not disturbed.
- When there is no loader write and no accepted bus write, mem_we=0. mem_addr=wb_adr_i in IDLE, otherwise the loader address.
- Arithmetic: address add is ADDR_WIDTH bits, wrapping at 2**ADDR_WIDTH-1 -> 0.

Test Plan:
- Reset, then ld_start base=0x010, stream 8 bytes 0x11..0x88 back-to-back, last on 0x88 -> mem_we=4'hF at 0x010 with data 0x44332211, then at 0x011 with data 0x88776655; ld_done one pulse; ld_word_cnt=2.
- Load base=0x020, 6 bytes 0xA0..0xA5, last on 0xA5 -> second write mem_we=4'b0011 at 0x021, data[15:0]=0xA5A4; ld_word_cnt=2.
- Load base=0xFFF, 8 bytes -> writes at 0xFFF then 0x000 (wrap); ld_busy low after the FLUSH write.
- Bus write adr=0x005 sel=4'b0100 dat=0x00CC0000, then read 0x005 with RAM model -> ack exactly 1 cycle after each accept; read returns byte2=0xCC, other bytes unchanged.
- wb_stb_i held high during a 4-byte load -> no ack until IDLE; after ld_done, read completes with loaded data.
- Assert reset_n low after 2 of 4 bytes -> no RAM write; outputs 0; a subsequent load starts cleanly from column 0.
